// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle RV32I datapath: fetch, decode, execute, memory, write-back.
// Optional retired-instruction counter enabled by defining MCTRL_INSTRET_EN.
module multicycle_ctrl #(
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  input  logic                  imem_ready,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  output logic                  dmem_req,
  output logic                  dmem_we,
  input  logic                  dmem_ready,
  output logic [INST_WIDTH-1:0] inst_out,
  output logic [2:0]            imm_src,
  output logic                  pc_we,
  output logic                  rf_we,
  output logic                  halted,
  output logic                  illegal,
  output logic [2:0]            state_o,
  output logic [CNT_WIDTH-1:0]  instret
);

  // Immediate-type encodings shared with the extender.
  localparam logic [2:0] R_IMM     = 3'd0;
  localparam logic [2:0] I_IMM     = 3'd1;
  localparam logic [2:0] S_IMM     = 3'd2;
  localparam logic [2:0] B_IMM     = 3'd3;
  localparam logic [2:0] U_IMM     = 3'd4;
  localparam logic [2:0] J_IMM     = 3'd5;
  localparam logic [2:0] SHAMT_IMM = 3'd6;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  localparam logic [INST_WIDTH-1:0] Ebreak = INST_WIDTH'(32'h00100073);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5,
    StTrap   = 3'd6
  } state_e;

  state_e                  state_q, state_d, dec_next;
  logic [INST_WIDTH-1:0]   inst_q;
  logic [2:0]              imm_q, imm_dec;
  // Low for the first cycle out of reset so imem_req rises one cycle after rst falls.
  logic                    run_q;
  logic [6:0]              opcode;
  logic [2:0]              funct3;
  logic                    is_store, is_load;

  assign opcode   = inst_q[6:0];
  assign funct3   = inst_q[14:12];
  assign is_store = (opcode == OpStore);
  assign is_load  = (opcode == OpLoad);

  always_comb begin
    imm_dec  = imm_q;
    dec_next = StTrap;
    if (inst_q == Ebreak) begin
      dec_next = StHalt;
    end else begin
      case (opcode)
        OpLui, OpAuipc:   begin imm_dec = U_IMM; dec_next = StExec; end
        OpJal:            begin imm_dec = J_IMM; dec_next = StExec; end
        OpJalr, OpLoad:   begin imm_dec = I_IMM; dec_next = StExec; end
        OpImm: begin
          imm_dec  = (funct3 == 3'b001 || funct3 == 3'b101) ? SHAMT_IMM : I_IMM;
          dec_next = StExec;
        end
        OpStore:          begin imm_dec = S_IMM; dec_next = StExec; end
        OpBranch:         begin imm_dec = B_IMM; dec_next = StExec; end
        OpReg:            begin imm_dec = R_IMM; dec_next = StExec; end
        default:          begin imm_dec = imm_q; dec_next = StTrap; end
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    pc_we    = 1'b0;
    rf_we    = 1'b0;
    case (state_q)
      StFetch: begin
        imem_req = run_q;
        if (run_q && imem_ready) state_d = StDecode;
      end
      StDecode: state_d = dec_next;
      StExec: begin
        if (opcode == OpBranch) begin
          pc_we   = 1'b1;
          state_d = StFetch;
        end else if (is_load || is_store) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ready) begin
          // Store retires in its completion cycle to keep the 4-cycle store latency.
          pc_we   = is_store;
          state_d = is_store ? StFetch : StWb;
        end
      end
      StWb: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        state_d = StFetch;
      end
      StHalt:  state_d = StHalt;
      StTrap:  state_d = StTrap;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      run_q   <= 1'b0;
      inst_q  <= '0;
      imm_q   <= R_IMM;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      if (state_q == StFetch && run_q && imem_ready) inst_q <= imem_rdata;
      if (state_q == StDecode) imm_q <= imm_dec;
    end
  end

  assign inst_out = inst_q;
  assign imm_src  = imm_q;
  assign halted   = (state_q == StHalt);
  assign illegal  = (state_q == StTrap);
  assign state_o  = state_q;

`ifdef MCTRL_INSTRET_EN
  logic [CNT_WIDTH-1:0] instret_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      instret_q <= '0;
    end else if (pc_we) begin
      instret_q <= instret_q + 1'b1;
    end
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle vector table plus directed corner sequences.
module tb_multicycle_ctrl;

  logic        clk, rst;
  logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready;
  logic [31:0] imem_rdata, inst_out, instret;
  logic [2:0]  imm_src, state_o;
  logic        pc_we, rf_we, halted, illegal;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_ctrl #(.INST_WIDTH(32), .CNT_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_ready (dmem_ready),
    .inst_out   (inst_out),
    .imm_src    (imm_src),
    .pc_we      (pc_we),
    .rf_we      (rf_we),
    .halted     (halted),
    .illegal    (illegal),
    .state_o    (state_o),
    .instret    (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] R = 3'd0, I = 3'd1, S = 3'd2, B = 3'd3, U = 3'd4, J = 3'd5, SH = 3'd6;
  localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, W = 3'd4, H = 3'd5, T = 3'd6;

  localparam logic [31:0] ADDI = 32'h00500093, LW = 32'h0000a103, SW = 32'h0020a023;
  localparam logic [31:0] BEQ = 32'h00208463, SLLI = 32'h00309093, BAD = 32'h0000007f;
  localparam logic [31:0] EBRK = 32'h00100073;

  typedef struct {
    logic        rst, ir, dr;
    logic [31:0] rdata;
    logic [2:0]  st;
    logic        ireq, dreq, dwe, pcwe, rfwe;
    logic [2:0]  imm;
    logic        ill;
    logic [31:0] inst;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic ir, input logic [31:0] rd, input logic dr,
                     input logic [2:0] st, input logic ireq, input logic dreq, input logic dwe,
                     input logic pcwe, input logic rfwe, input logic [2:0] imm, input logic ill,
                     input logic [31:0] inst, input logic [31:0] cnt);
    vec_t v;
    v.rst = r; v.ir = ir; v.rdata = rd; v.dr = dr; v.st = st; v.ireq = ireq; v.dreq = dreq;
    v.dwe = dwe; v.pcwe = pcwe; v.rfwe = rfwe; v.imm = imm; v.ill = ill; v.inst = inst;
    v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input logic [31:0] c);
`ifdef MCTRL_INSTRET_EN
    return c;
`else
    return (c == 32'd0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic run_one(input string name, input logic [31:0] w, input logic [2:0] eimm,
                         input int elat);
    int cyc;
    logic [2:0] got;
    got = 3'd7;
    check({name, " start_fetch"}, {29'd0, state_o}, {29'd0, F});
    imem_ready = 1'b1; imem_rdata = w; cyc = 1;
    @(posedge clk); #1;
    imem_ready = 1'b0;
    while (state_o != F && cyc < 20) begin
      if (state_o == E) got = imm_src;
      cyc++;
      @(posedge clk); #1;
    end
    check({name, " imm_src"}, {29'd0, got}, {29'd0, eimm});
    check({name, " latency"}, cyc, elat);
  endtask

  initial begin
    int found;
    rst = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; imem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset state", {29'd0, state_o}, {29'd0, F});
    check("reset ctl", {27'd0, imem_req, dmem_req, dmem_we, pc_we, rf_we}, 32'd0);
    check("reset inst_out", inst_out, 32'd0);
    check("reset imm_src", {29'd0, imm_src}, {29'd0, R});
    check("reset flags", {30'd0, halted, illegal}, 32'd0);
    check("reset instret", instret, 32'd0);

    //  rst ir rdata  dr  st ireq dreq dwe pc rf imm ill inst  cnt
    add(0, 0, '0,   0, F, 0, 0, 0, 0, 0, R, 0, '0,   0);
    add(0, 1, ADDI, 0, F, 1, 0, 0, 0, 0, R, 0, '0,   0);
    add(0, 0, '0,   0, D, 0, 0, 0, 0, 0, R, 0, ADDI, 0);
    add(0, 0, '0,   0, E, 0, 0, 0, 0, 0, I, 0, ADDI, 0);
    add(0, 0, '0,   0, W, 0, 0, 0, 1, 1, I, 0, ADDI, 0);
    add(0, 0, '0,   1, F, 1, 0, 0, 0, 0, I, 0, ADDI, 1);
    add(0, 1, LW,   0, F, 1, 0, 0, 0, 0, I, 0, ADDI, 1);
    add(0, 0, '0,   0, D, 0, 0, 0, 0, 0, I, 0, LW,   1);
    add(0, 0, '0,   0, E, 0, 0, 0, 0, 0, I, 0, LW,   1);
    add(0, 0, '0,   0, M, 0, 1, 0, 0, 0, I, 0, LW,   1);
    add(0, 0, '0,   0, M, 0, 1, 0, 0, 0, I, 0, LW,   1);
    add(0, 0, '0,   0, M, 0, 1, 0, 0, 0, I, 0, LW,   1);
    add(0, 0, '0,   1, M, 0, 1, 0, 0, 0, I, 0, LW,   1);
    add(0, 0, '0,   0, W, 0, 0, 0, 1, 1, I, 0, LW,   1);
    add(0, 1, SW,   0, F, 1, 0, 0, 0, 0, I, 0, LW,   2);
    add(0, 0, '0,   0, D, 0, 0, 0, 0, 0, I, 0, SW,   2);
    add(0, 0, '0,   0, E, 0, 0, 0, 0, 0, S, 0, SW,   2);
    add(0, 0, '0,   1, M, 0, 1, 1, 1, 0, S, 0, SW,   2);
    add(0, 1, BEQ,  0, F, 1, 0, 0, 0, 0, S, 0, SW,   3);
    add(0, 0, '0,   0, D, 0, 0, 0, 0, 0, S, 0, BEQ,  3);
    add(0, 0, '0,   0, E, 0, 0, 0, 1, 0, B, 0, BEQ,  3);
    add(0, 1, SLLI, 0, F, 1, 0, 0, 0, 0, B, 0, BEQ,  4);
    add(0, 0, '0,   0, D, 0, 0, 0, 0, 0, B, 0, SLLI, 4);
    add(0, 0, '0,   0, E, 0, 0, 0, 0, 0, SH, 0, SLLI, 4);
    add(0, 0, '0,   0, W, 0, 0, 0, 1, 1, SH, 0, SLLI, 4);
    add(0, 1, BAD,  0, F, 1, 0, 0, 0, 0, SH, 0, SLLI, 5);
    add(0, 0, '0,   0, D, 0, 0, 0, 0, 0, SH, 0, BAD,  5);
    add(0, 1, ADDI, 0, T, 0, 0, 0, 0, 0, SH, 1, BAD,  5);
    add(0, 0, '0,   1, T, 0, 0, 0, 0, 0, SH, 1, BAD,  5);
    add(1, 0, '0,   0, T, 0, 0, 0, 0, 0, SH, 1, BAD,  5);
    add(1, 0, '0,   0, F, 0, 0, 0, 0, 0, R, 0, '0,   0);
    add(0, 0, '0,   0, F, 0, 0, 0, 0, 0, R, 0, '0,   0);
    add(0, 0, '0,   0, F, 1, 0, 0, 0, 0, R, 0, '0,   0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; imem_ready = vecs[i].ir; imem_rdata = vecs[i].rdata;
      dmem_ready = vecs[i].dr;
      #1;
      check($sformatf("vec%0d ctl", i),
            {19'd0, state_o, imem_req, dmem_req, dmem_we, pc_we, rf_we, imm_src, halted, illegal},
            {19'd0, vecs[i].st, vecs[i].ireq, vecs[i].dreq, vecs[i].dwe, vecs[i].pcwe,
             vecs[i].rfwe, vecs[i].imm, 1'b0, vecs[i].ill});
      check($sformatf("vec%0d inst_out", i), inst_out, vecs[i].inst);
      check($sformatf("vec%0d instret", i), instret, exp_cnt(vecs[i].cnt));
      @(posedge clk); #1;
    end
    imem_ready = 1'b0; dmem_ready = 1'b0; rst = 1'b0;

    run_one("lui",   32'h000010b7, U, 4);
    run_one("auipc", 32'h00001097, U, 4);
    run_one("jal",   32'h008000ef, J, 4);
    run_one("jalr",  32'h000080e7, I, 4);
    run_one("add",   32'h002081b3, R, 4);
    run_one("srai",  32'h4010d093, SH, 4);
    run_one("bne",   32'h00209463, B, 3);

    // ebreak: halt and stay put with no strobes, ignoring stray readies.
    imem_ready = 1'b1; imem_rdata = EBRK;
    @(posedge clk); #1;
    imem_ready = 1'b0;
    check("ebreak decode", {29'd0, state_o}, {29'd0, D});
    @(posedge clk); #1;
    imem_ready = 1'b1; dmem_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #1;
      check($sformatf("halt cyc%0d", k),
            {22'd0, state_o, halted, illegal, imem_req, dmem_req, pc_we, rf_we},
            {22'd0, H, 1'b1, 1'b0, 4'b0000});
      @(posedge clk); #1;
    end
    imem_ready = 1'b0; dmem_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("halt cleared by rst", {29'd0, state_o, halted}, {29'd0, F, 1'b0});
    rst = 1'b0;
    @(posedge clk); #1;
    check("post-rst req", {31'd0, imem_req}, 32'd1);

    // Reset while waiting on imem, late ready during reset must be ignored.
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    imem_ready = 1'b1; imem_rdata = ADDI;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("late ready inst_out", inst_out, 32'd0);
    check("late ready state", {30'd0, state_o, imem_req}, {30'd0, F, 1'b0});
    imem_ready = 1'b0; rst = 1'b0;
    found = 0;
    for (int k = 0; k < 5 && found == 0; k++) begin
      @(posedge clk); #1;
      if (imem_req) found = k + 1;
    end
    check("fresh imem_req cycles", found, 1);
    check("fresh inst_out", inst_out, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
